// File: rtl/radar_if_pkg.sv
// Shared definitions for the radar timing interface (board and receiver sides).
// State encodings and default revolution/sweep geometry.
package radar_if_pkg;

  typedef enum logic {
    SWEEP_IDLE   = 1'b0,
    SWEEP_ACTIVE = 1'b1
  } sweep_state_e;

  typedef enum logic {
    AZ_UNLOCKED = 1'b0,
    AZ_LOCKED   = 1'b1
  } lock_state_e;

  localparam int DEF_ACP_PER_REV = 4096;
  localparam int DEF_RANGE_BINS  = 512;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level line followed by a
// registered one-cycle pulse on each rising edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/radar_if_receiver.sv
// Receiver for the radar timing interface: rebuilds antenna azimuth from
// ARP/ACP and generates per-sweep range-bin timing from the trigger.
module radar_if_receiver
  import radar_if_pkg::*;
#(
  parameter int ACP_PER_REV = DEF_ACP_PER_REV,
  parameter int AZ_W        = 12,
  parameter int RANGE_BINS  = DEF_RANGE_BINS,
  parameter int RANGE_W     = 9,
  parameter int BIN_DIV     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arp,
  input  logic               acp,
  input  logic               trig,
  output logic [AZ_W-1:0]    azimuth,
  output logic               az_locked,
  output logic [AZ_W:0]      acp_per_rev,
  output logic               arp_missing,
  output logic               sweep_start,
  output logic [AZ_W-1:0]    sweep_az,
  output logic               sweep_active,
  output logic               sample_strobe,
  output logic [RANGE_W-1:0] range_bin,
  output logic               sweep_done,
  output logic               retrig
);

  localparam int DIV_W = (BIN_DIV > 1) ? $clog2(BIN_DIV) : 1;
  localparam logic [AZ_W-1:0]    LAST_AZ  = AZ_W'(ACP_PER_REV - 1);
  localparam logic [RANGE_W-1:0] LAST_BIN = RANGE_W'(RANGE_BINS - 1);
  localparam logic [DIV_W-1:0]   LAST_DIV = DIV_W'(BIN_DIV - 1);

  function automatic logic [AZ_W:0] sat_inc(input logic [AZ_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic arp_ev, acp_ev, trig_ev;

  sync_edge_detect u_arp  (.clk(clk), .rst_n(rst), .d_i(arp),  .rise_o(arp_ev));
  sync_edge_detect u_acp  (.clk(clk), .rst_n(rst), .d_i(acp),  .rise_o(acp_ev));
  sync_edge_detect u_trig (.clk(clk), .rst_n(rst), .d_i(trig), .rise_o(trig_ev));

  lock_state_e        lock_q, lock_d;
  sweep_state_e       sw_q, sw_d;
  logic [AZ_W-1:0]    az_q, az_d, saz_q, saz_d;
  logic [AZ_W:0]      rev_q, rev_d, apr_q, apr_d;
  logic               miss_q, miss_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [RANGE_W-1:0] rb_q, rb_d;
  logic               start_q, start_d, strobe_q, strobe_d;
  logic               done_q, done_d, retrig_q, retrig_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q   <= AZ_UNLOCKED;
      sw_q     <= SWEEP_IDLE;
      az_q     <= '0;
      saz_q    <= '0;
      rev_q    <= '0;
      apr_q    <= '0;
      miss_q   <= 1'b0;
      div_q    <= '0;
      rb_q     <= '0;
      start_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      retrig_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      sw_q     <= sw_d;
      az_q     <= az_d;
      saz_q    <= saz_d;
      rev_q    <= rev_d;
      apr_q    <= apr_d;
      miss_q   <= miss_d;
      div_q    <= div_d;
      rb_q     <= rb_d;
      start_q  <= start_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      retrig_q <= retrig_d;
    end
  end

  always_comb begin
    lock_d = lock_q;
    az_d   = az_q;
    rev_d  = rev_q;
    apr_d  = apr_q;
    miss_d = miss_q;
    case (lock_q)
      AZ_UNLOCKED: begin
        if (arp_ev) begin
          lock_d = AZ_LOCKED;
          az_d   = '0;
          rev_d  = '0;
        end
      end
      AZ_LOCKED: begin
        // A coincident ACP still belongs to the revolution being closed.
        if (arp_ev) begin
          apr_d  = acp_ev ? sat_inc(rev_q) : rev_q;
          az_d   = '0;
          rev_d  = '0;
          miss_d = 1'b0;
        end else if (acp_ev) begin
          rev_d = sat_inc(rev_q);
          if (az_q == LAST_AZ) begin
            az_d   = '0;
            miss_d = 1'b1;
          end else begin
            az_d = az_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    sw_d     = sw_q;
    div_d    = div_q;
    rb_d     = rb_q;
    saz_d    = saz_q;
    start_d  = 1'b0;
    strobe_d = 1'b0;
    retrig_d = 1'b0;
    if (trig_ev) begin
      retrig_d = (sw_q == SWEEP_ACTIVE);
      sw_d     = SWEEP_ACTIVE;
      start_d  = 1'b1;
      strobe_d = 1'b1;
      rb_d     = '0;
      div_d    = '0;
      saz_d    = az_d;
    end else if (sw_q == SWEEP_ACTIVE) begin
      // The last bin still occupies a full BIN_DIV period before going idle.
      if (div_q == LAST_DIV) begin
        div_d = '0;
        if (rb_q == LAST_BIN) begin
          sw_d = SWEEP_IDLE;
        end else begin
          strobe_d = 1'b1;
          rb_d     = rb_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    done_d = strobe_d && (rb_d == LAST_BIN);
  end

  assign azimuth       = az_q;
  assign az_locked     = (lock_q == AZ_LOCKED);
  assign acp_per_rev   = apr_q;
  assign arp_missing   = miss_q;
  assign sweep_start   = start_q;
  assign sweep_az      = saz_q;
  assign sweep_active  = (sw_q == SWEEP_ACTIVE);
  assign sample_strobe = strobe_q;
  assign range_bin     = rb_q;
  assign sweep_done    = done_q;
  assign retrig        = retrig_q;

endmodule

// File: tb/tb_radar_if_receiver.sv
// Self-checking bench for radar_if_receiver with a small geometry
// (16 ACP/rev, 8 range bins, 4 clocks per bin).
module tb_radar_if_receiver;

  localparam int ACP_PER_REV = 16;
  localparam int AZ_W        = 4;
  localparam int RANGE_BINS  = 8;
  localparam int RANGE_W     = 3;
  localparam int BIN_DIV     = 4;
  localparam int LAT         = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arp = 1'b0, acp = 1'b0, trig = 1'b0;

  logic [AZ_W-1:0]    azimuth, sweep_az;
  logic [AZ_W:0]      acp_per_rev;
  logic [RANGE_W-1:0] range_bin;
  logic az_locked, arp_missing, sweep_start, sweep_active;
  logic sample_strobe, sweep_done, retrig;

  radar_if_receiver #(
    .ACP_PER_REV(ACP_PER_REV), .AZ_W(AZ_W), .RANGE_BINS(RANGE_BINS),
    .RANGE_W(RANGE_W), .BIN_DIV(BIN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .arp(arp), .acp(acp), .trig(trig),
    .azimuth(azimuth), .az_locked(az_locked), .acp_per_rev(acp_per_rev),
    .arp_missing(arp_missing), .sweep_start(sweep_start), .sweep_az(sweep_az),
    .sweep_active(sweep_active), .sample_strobe(sample_strobe),
    .range_bin(range_bin), .sweep_done(sweep_done), .retrig(retrig)
  );

  always #10 clk = ~clk;

  logic [22:0] dut_vec;
  assign dut_vec = {azimuth, az_locked, acp_per_rev, arp_missing, sweep_start,
                    sweep_az, sweep_active, sample_strobe, range_bin,
                    sweep_done, retrig};

  int errors = 0;
  int checks = 0;

  // Reference model: events appear LAT cycles after the first sampled high;
  // the sweep is described by elapsed cycles since its trigger.
  int m_az, m_cnt, m_apr, m_saz, m_t, m_rb;
  bit m_lock, m_miss, m_active, m_start, m_retrig;
  bit [2:0] m_prev;
  bit [2:0] m_dly [LAT];

  task automatic model_reset();
    m_az = 0; m_cnt = 0; m_apr = 0; m_saz = 0; m_t = 0; m_rb = 0;
    m_lock = 0; m_miss = 0; m_active = 0; m_start = 0; m_retrig = 0;
    m_prev = '0;
    for (int i = 0; i < LAT; i++) m_dly[i] = '0;
  endtask

  task automatic model_step();
    bit [2:0] cur, ev;
    cur = {arp, acp, trig};
    ev = m_dly[LAT-1];
    for (int i = LAT-1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = cur & ~m_prev;
    m_prev = cur;
    if (!m_lock) begin
      if (ev[2]) begin m_lock = 1; m_az = 0; m_cnt = 0; end
    end else if (ev[2]) begin
      m_apr = m_cnt + (ev[1] ? 1 : 0);
      if (m_apr > 31) m_apr = 31;
      m_az = 0; m_cnt = 0; m_miss = 0;
    end else if (ev[1]) begin
      m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
      m_az = (m_az + 1) % ACP_PER_REV;
      if (m_az == 0) m_miss = 1;
    end
    m_start = ev[0];
    m_retrig = ev[0] && m_active;
    if (ev[0]) begin
      m_active = 1; m_t = 0; m_saz = m_az;
    end else if (m_active) begin
      m_t++;
      if (m_t >= RANGE_BINS * BIN_DIV) m_active = 0;
    end
    if (m_active) m_rb = m_t / BIN_DIV;
  endtask

  function automatic logic [22:0] exp_vec();
    bit strobe, done;
    strobe = m_active && (m_t % BIN_DIV == 0);
    done = strobe && (m_t / BIN_DIV == RANGE_BINS - 1);
    return {4'(m_az), m_lock, 5'(m_apr), m_miss, m_start, 4'(m_saz),
            m_active, strobe, 3'(m_rb), done, m_retrig};
  endfunction

  logic [2:0] sched [$];

  task automatic push_pulse(input logic [2:0] l, input int w, input int g);
    for (int i = 0; i < w; i++) sched.push_back(l);
    for (int i = 0; i < g; i++) sched.push_back(3'b000);
  endtask

  task automatic run(input logic [2:0] l);
    {arp, acp, trig} = l;
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run((i % 2 == 0) ? 3'b011 : 3'b000);
      checks++;
      if (dut_vec !== 23'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected 0", i, dut_vec);
      end
    end
    rst = 1'b1;
    sched.delete();
    for (int i = 0; i < 4; i++) push_pulse(3'b010, $urandom_range(1, 3), $urandom_range(1, 4));
    push_pulse(3'b000, 0, 4);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_unlocked[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (azimuth !== 4'd0 || az_locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_lock: az=%0d locked=%b expected 0/0", azimuth, az_locked);
    end
  endtask

  task automatic test_lock();
    int base;
    sched.delete();
    push_pulse(3'b100, 2, 6);
    base = sched.size();
    push_pulse(3'b010, 1, 5);
    for (int i = 0; i < 4; i++) push_pulse(3'b010, $urandom_range(1, 3), $urandom_range(1, 4));
    push_pulse(3'b100, $urandom_range(1, 3), 6);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lock[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (i == base + LAT - 1) begin
        checks++;
        if (azimuth !== 4'd0) begin
          errors++;
          $display("FAIL lock_latency_early: az=%0d expected 0", azimuth);
        end
      end
      if (i == base + LAT) begin
        checks++;
        if (azimuth !== 4'd1) begin
          errors++;
          $display("FAIL lock_latency: az=%0d expected 1", azimuth);
        end
      end
    end
    checks++;
    if (az_locked !== 1'b1 || acp_per_rev !== 5'd5 || azimuth !== 4'd0) begin
      errors++;
      $display("FAIL lock_final: locked=%b apr=%0d az=%0d expected 1/5/0",
               az_locked, acp_per_rev, azimuth);
    end
  endtask

  task automatic test_wrap();
    sched.delete();
    for (int i = 0; i < 16; i++) push_pulse(3'b010, $urandom_range(1, 2), $urandom_range(1, 3));
    push_pulse(3'b000, 0, 4);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (arp_missing !== 1'b1 || azimuth !== 4'd0) begin
      errors++;
      $display("FAIL wrap_missing: miss=%b az=%0d expected 1/0", arp_missing, azimuth);
    end
    sched.delete();
    push_pulse(3'b100, 1, 5);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_arp[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (arp_missing !== 1'b0 || acp_per_rev !== 5'd16) begin
      errors++;
      $display("FAIL wrap_clear: miss=%b apr=%0d expected 0/16", arp_missing, acp_per_rev);
    end
  endtask

  task automatic test_sweep();
    int act, strb, dn, saz;
    act = 0; strb = 0; dn = 0; saz = -1;
    sched.delete();
    for (int i = 0; i < 7; i++) push_pulse(3'b010, 1, $urandom_range(1, 3));
    push_pulse(3'b000, 0, 4);
    push_pulse(3'b001, 2, 42);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL sweep[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      act += int'(sweep_active);
      strb += int'(sample_strobe);
      dn += int'(sweep_done);
      if (sweep_start === 1'b1) saz = int'(sweep_az);
    end
    checks++;
    if (act != 32 || strb != 8 || dn != 1 || saz != 7) begin
      errors++;
      $display("FAIL sweep_totals: active=%0d strobes=%0d done=%0d az=%0d expected 32/8/1/7",
               act, strb, dn, saz);
    end
    checks++;
    if (range_bin !== 3'd7 || sweep_active !== 1'b0) begin
      errors++;
      $display("FAIL sweep_idle: bin=%0d active=%b expected 7/0", range_bin, sweep_active);
    end
  endtask

  task automatic test_retrig();
    bit found;
    int rt, dn;
    found = 0; rt = 0; dn = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run((i == 0) ? 3'b001 : 3'b000);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL retrig_pre[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (range_bin === 3'd3 && sample_strobe === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL retrig_wait: bin 3 not reached, bin=%0d", range_bin);
    end
    for (int i = 0; i < 45; i++) begin
      run((i == 0) ? 3'b001 : 3'b000);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL retrig[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (retrig === 1'b1) begin
        rt++;
        checks++;
        if (sweep_start !== 1'b1 || range_bin !== 3'd0 || dn != 0) begin
          errors++;
          $display("FAIL retrig_restart: start=%b bin=%0d done_before=%0d expected 1/0/0",
                   sweep_start, range_bin, dn);
        end
      end
      dn += int'(sweep_done);
    end
    checks++;
    if (rt != 1 || dn != 1) begin
      errors++;
      $display("FAIL retrig_counts: retrig=%0d done=%0d expected 1/1", rt, dn);
    end
  endtask

  task automatic test_coincident();
    sched.delete();
    push_pulse(3'b100, 1, 5);
    for (int i = 0; i < 9; i++) push_pulse(3'b010, 1, $urandom_range(1, 3));
    push_pulse(3'b110, 2, 6);
    push_pulse(3'b001, 1, 10);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL coinc[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (azimuth !== 4'd0 || acp_per_rev !== 5'd10 || sweep_active !== 1'b1) begin
      errors++;
      $display("FAIL coinc_final: az=%0d apr=%0d active=%b expected 0/10/1",
               azimuth, acp_per_rev, sweep_active);
    end
    #3 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (sweep_active !== 1'b0 || dut_vec !== 23'd0) begin
      errors++;
      $display("FAIL midsweep_reset: got %h expected 0", dut_vec);
    end
    run(3'b000);
    run(3'b000);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(3'b000);
      checks++;
      if (dut_vec !== exp_vec() || sweep_done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    sched.delete();
    for (int i = 0; i < 60; i++)
      push_pulse(3'($urandom_range(1, 7)), $urandom_range(1, 3), $urandom_range(1, 14));
    push_pulse(3'b000, 0, 40);
    foreach (sched[i]) begin
      run(sched[i]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_sweep();
    test_retrig();
    test_coincident();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
